// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: m0 has fixed priority,
// and defining DMEM_ARB_STARVE_EN adds a starvation guard that lifts m1 after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    if (MAX_WAIT < 1) begin : g_bad_param
        $error("dmem_arbiter: MAX_WAIT must be at least 1");
    end

    logic gnt0, gnt1;
    logic prio;
    logic pend0, pend1;

`ifdef DMEM_ARB_STARVE_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {ST_NORMAL, ST_M1_PRIO} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt, wait_nxt;

    // A grant to m1 clears the counter before it can arm the priority state.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!m1_req || gnt1)
            wait_nxt = '0;
        else if (wait_cnt != CW'(MAX_WAIT))
            wait_nxt = wait_cnt + 1'b1;
    end

    // Priority is armed on the same edge the counter reaches MAX_WAIT, so it
    // takes effect in the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_NORMAL;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            case (state)
                ST_NORMAL:  if (wait_nxt == CW'(MAX_WAIT)) state <= ST_M1_PRIO;
                ST_M1_PRIO: if (gnt1 || !m1_req)           state <= ST_NORMAL;
                default:                                   state <= ST_NORMAL;
            endcase
        end
    end

    assign prio = (state == ST_M1_PRIO);
`else
    assign prio = 1'b0;
`endif

    assign gnt1 = !reset && m1_req && (!m0_req || prio);
    assign gnt0 = !reset && m0_req && !gnt1;

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign mem_en = gnt0 || gnt1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Remember which port owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            pend0 <= gnt0 && !m0_we;
            pend1 <= gnt1 && !m1_we;
        end
    end

    // Gating with reset drops a read whose return cycle collides with reset.
    assign m0_rvalid = pend0 && !reset;
    assign m1_rvalid = pend1 && !reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule
